// File: rtl/cnn_conv_engine_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared types and constants for the sequential K x K convolution
//            MAC engine: FSM state encoding, default widths and the helper
//            that derives the number of accumulation beats.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Default build parameters shared by the interface, lane and engine.
    localparam int unsigned c_DEF_DATA_WIDTH  = 8;
    localparam int unsigned c_DEF_ACC_WIDTH   = 32;
    localparam int unsigned c_DEF_KERNEL_SIZE = 3;
    localparam int unsigned c_DEF_LANES       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } cnn_conv_state_e;

    // Beats needed to consume n taps with `lanes` multipliers per beat.
    function automatic int unsigned cnn_beats(input int unsigned n,
                                              input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage : cnn_pkg

`default_nettype wire

// File: rtl/cnn_conv_engine_if.sv
// ============================================================================
// Module   : cnn_conv_engine_if
// Purpose  : Handshake/data bundle of the convolution engine.
//            slave  modport : seen by the engine
//            master modport : seen by the producer/consumer driving it
// Signals  : flush_i, in_valid_i, in_ready_o, window_i, weight_i, bias_i,
//            out_valid_o, out_ready_i, result_o, busy_o
//            (_i / _o suffixes are from the engine's point of view)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnn_conv_engine_if
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH   = c_DEF_ACC_WIDTH,
    parameter int unsigned KERNEL_SIZE = c_DEF_KERNEL_SIZE
);
    localparam int unsigned N_TAPS = KERNEL_SIZE * KERNEL_SIZE;

    logic                         flush_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [N_TAPS*DATA_WIDTH-1:0] window_i;
    logic [N_TAPS*DATA_WIDTH-1:0] weight_i;
    logic [ACC_WIDTH-1:0]         bias_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [ACC_WIDTH-1:0]         result_o;
    logic                         busy_o;

    modport slave (
        input  flush_i, in_valid_i, window_i, weight_i, bias_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );

    modport master (
        output flush_i, in_valid_i, window_i, weight_i, bias_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

endinterface : cnn_conv_engine_if

`default_nettype wire

// File: rtl/cnn_conv_engine_mac_lane.sv
// ============================================================================
// Module   : cnn_mac_lane
// Purpose  : Combinational LANES-wide signed multiply plus reduction. Lane l
//            multiplies tap (idx_i + l); lanes past the last tap contribute 0.
//            Products are sign-extended to ACC_WIDTH and summed modulo
//            2^ACC_WIDTH into one partial sum per beat.
// Ports    : window_i  N_TAPS*DATA_WIDTH  latched pixels, row-major
//            weight_i  N_TAPS*DATA_WIDTH  latched weights, row-major
//            idx_i     IDX_W              first tap of this beat
//            psum_o    ACC_WIDTH          signed partial sum of the beat
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_mac_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = c_DEF_ACC_WIDTH,
    parameter int unsigned N_TAPS     = 9,
    parameter int unsigned LANES      = c_DEF_LANES,
    parameter int unsigned IDX_W      = 5
) (
    input  wire logic [N_TAPS*DATA_WIDTH-1:0] window_i,
    input  wire logic [N_TAPS*DATA_WIDTH-1:0] weight_i,
    input  wire logic [IDX_W-1:0]             idx_i,
    output logic      [ACC_WIDTH-1:0]         psum_o
);

    logic signed [ACC_WIDTH-1:0] w_ext [LANES];
    logic signed [ACC_WIDTH-1:0] w_sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0]               w_tap;
        logic signed [DATA_WIDTH-1:0]   w_px;
        logic signed [DATA_WIDTH-1:0]   w_wt;
        logic signed [2*DATA_WIDTH-1:0] w_prod;

        assign w_tap = idx_i + IDX_W'(l);

        // Constant-index tap mux; an out-of-range tap matches nothing and
        // leaves the operands at zero, which zeroes the tail lanes.
        always_comb begin
            w_px = '0;
            w_wt = '0;
            for (int t = 0; t < int'(N_TAPS); t++) begin
                if (w_tap == IDX_W'(t)) begin
                    w_px = window_i[t*DATA_WIDTH +: DATA_WIDTH];
                    w_wt = weight_i[t*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign w_prod   = w_px * w_wt;
        assign w_ext[l] = ACC_WIDTH'(w_prod);
    end

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_sum = w_sum + w_ext[l];
        end
    end

    assign psum_o = w_sum;

endmodule : cnn_mac_lane

`default_nettype wire

// File: rtl/cnn_conv_engine.sv
// ============================================================================
// Module   : cnn_conv_engine
// Purpose  : Sequential K x K convolution MAC engine. Accepts one window,
//            weight set and bias per transaction, accumulates LANES products
//            per beat starting from the bias, and returns one ACC_WIDTH
//            result over a valid/ready handshake. flush_i aborts to IDLE.
//            Optional feature: define CNN_CONV_RELU_EN to clamp negative
//            results to zero when the result is registered.
// Ports    : clk_i    clock
//            rst_i    asynchronous reset, active-high
//            conv_if  cnn_conv_engine_if.slave (flush, input handshake with
//                     window/weight/bias, output handshake with result, busy)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_conv_engine
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH   = c_DEF_ACC_WIDTH,
    parameter int unsigned KERNEL_SIZE = c_DEF_KERNEL_SIZE,
    parameter int unsigned LANES       = c_DEF_LANES
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    cnn_conv_engine_if.slave   conv_if
);

    localparam int unsigned N_TAPS = KERNEL_SIZE * KERNEL_SIZE;
    // Holds idx + LANES on the final beat without overflowing.
    localparam int unsigned IDX_W  = $clog2(N_TAPS + 2 * LANES + 1);
    localparam int unsigned BEATS  = cnn_beats(N_TAPS, LANES);

    cnn_conv_state_e              state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [ACC_WIDTH-1:0]         acc_q;
    logic [N_TAPS*DATA_WIDTH-1:0] win_q;
    logic [N_TAPS*DATA_WIDTH-1:0] wgt_q;
    logic [ACC_WIDTH-1:0]         result_q;
    logic                         out_valid_q;
    logic                         in_ready_q;
    logic                         busy_q;

    logic [ACC_WIDTH-1:0]         psum;
    logic [ACC_WIDTH-1:0]         acc_d;
    logic [IDX_W-1:0]             idx_d;
    logic [ACC_WIDTH-1:0]         result_d;
    logic                         last_beat;

    cnn_mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .N_TAPS     (N_TAPS),
        .LANES      (LANES),
        .IDX_W      (IDX_W)
    ) u_mac_lane (
        .window_i (win_q),
        .weight_i (wgt_q),
        .idx_i    (idx_q),
        .psum_o   (psum)
    );

    assign acc_d     = acc_q + psum;
    assign idx_d     = idx_q + IDX_W'(LANES);
    assign last_beat = (idx_d >= IDX_W'(N_TAPS));

`ifdef CNN_CONV_RELU_EN
    assign result_d = acc_d[ACC_WIDTH-1] ? '0 : acc_d;
`else
    assign result_d = acc_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            wgt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (conv_if.flush_i) begin
            // Abort wins over any handshake this cycle; result_q is kept.
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (conv_if.in_valid_i) begin
                        win_q      <= conv_if.window_i;
                        wgt_q      <= conv_if.weight_i;
                        acc_q      <= conv_if.bias_i;
                        idx_q      <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_d;
                    if (last_beat) begin
                        result_q    <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (conv_if.out_ready_i) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    acc_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from flops: no input-to-output comb path.
    assign conv_if.in_ready_o  = in_ready_q;
    assign conv_if.out_valid_o = out_valid_q;
    assign conv_if.result_o    = result_q;
    assign conv_if.busy_o      = busy_q;

    // Kept for elaboration-time sanity of the beat count.
    if (BEATS < 1) begin : g_bad_cfg
        $error("cnn_conv_engine: LANES/KERNEL_SIZE give zero beats");
    end

endmodule : cnn_conv_engine

`default_nettype wire

// File: tb/tb_cnn_conv_engine.sv
// ============================================================================
// Module   : tb_cnn_conv_engine
// Purpose  : Self-checking bench. Three engines share one stimulus stream:
//            default (K=3, L=1, ACC=32), LANES=4, and ACC_WIDTH=16. Table of
//            hand-computed vectors plus backpressure, flush and reset
//            sequences. Honours CNN_CONV_RELU_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_conv_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [71:0] window = '0;
    logic [71:0] weight = '0;
    logic [31:0] bias = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cnn_conv_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .KERNEL_SIZE(3)) if_def ();
    cnn_conv_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .KERNEL_SIZE(3)) if_l4 ();
    cnn_conv_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .KERNEL_SIZE(3)) if_a16 ();

    assign if_def.flush_i = flush;     assign if_l4.flush_i = flush;     assign if_a16.flush_i = flush;
    assign if_def.in_valid_i = in_valid; assign if_l4.in_valid_i = in_valid; assign if_a16.in_valid_i = in_valid;
    assign if_def.out_ready_i = out_ready; assign if_l4.out_ready_i = out_ready; assign if_a16.out_ready_i = out_ready;
    assign if_def.window_i = window;   assign if_l4.window_i = window;   assign if_a16.window_i = window;
    assign if_def.weight_i = weight;   assign if_l4.weight_i = weight;   assign if_a16.weight_i = weight;
    assign if_def.bias_i = bias;       assign if_l4.bias_i = bias;       assign if_a16.bias_i = bias[15:0];

    cnn_conv_engine #(.DATA_WIDTH(8), .ACC_WIDTH(32), .KERNEL_SIZE(3), .LANES(1))
        u_def (.clk_i(clk), .rst_i(rst), .conv_if(if_def));
    cnn_conv_engine #(.DATA_WIDTH(8), .ACC_WIDTH(32), .KERNEL_SIZE(3), .LANES(4))
        u_l4 (.clk_i(clk), .rst_i(rst), .conv_if(if_l4));
    cnn_conv_engine #(.DATA_WIDTH(8), .ACC_WIDTH(16), .KERNEL_SIZE(3), .LANES(1))
        u_a16 (.clk_i(clk), .rst_i(rst), .conv_if(if_a16));

    typedef struct {
        logic [71:0] win;
        logic [71:0] wgt;
        logic [31:0] bias;
        logic [31:0] exp32;   // raw result, ACC_WIDTH=32
        logic [15:0] exp16;   // raw result, ACC_WIDTH=16
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [71:0] fill(input int base, input int step);
        logic [71:0] v;
        v = '0;
        for (int t = 0; t < 9; t++) v[t*8 +: 8] = 8'(base + step * t);
        return v;
    endfunction

    function automatic logic [31:0] relu32(input logic [31:0] v);
`ifdef CNN_CONV_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] relu16(input logic [15:0] v);
`ifdef CNN_CONV_RELU_EN
        return v[15] ? 16'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i);
        window = vecs[i].win;
        weight = vecs[i].wgt;
        bias   = vecs[i].bias;
    endtask

    // Offer vector i and let the acceptance edge pass; returns in cycle 1.
    task automatic accept(input int i);
        load(i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the default engine's out_valid.
    task automatic wait_def_valid(input string name);
        int c;
        c = 0;
        while (!if_def.out_valid_o && c < 20) begin
            tick();
            c++;
        end
        if (!if_def.out_valid_o) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int lat_def, lat_l4, lat_a16;
        lat_def = 0; lat_l4 = 0; lat_a16 = 0;
        accept(i);
        check($sformatf("v%0d_busy", i), 32'(if_def.busy_o), 32'd1);
        check($sformatf("v%0d_in_ready", i), 32'(if_def.in_ready_o), 32'd0);
        for (int c = 1; c <= 14; c++) begin
            if (lat_def == 0 && if_def.out_valid_o) lat_def = c;
            if (lat_l4  == 0 && if_l4.out_valid_o)  lat_l4  = c;
            if (lat_a16 == 0 && if_a16.out_valid_o) lat_a16 = c;
            tick();
        end
        check($sformatf("v%0d_lat_def", i), 32'(lat_def), 32'd10);
        check($sformatf("v%0d_lat_l4", i),  32'(lat_l4),  32'd4);
        check($sformatf("v%0d_res_def", i), if_def.result_o, relu32(vecs[i].exp32));
        check($sformatf("v%0d_res_l4", i),  if_l4.result_o,  relu32(vecs[i].exp32));
        check($sformatf("v%0d_res_a16", i), {16'd0, if_a16.result_o}, {16'd0, relu16(vecs[i].exp16)});
        handshake();
        check($sformatf("v%0d_valid_drop", i), 32'(if_def.out_valid_o), 32'd0);
        check($sformatf("v%0d_ready_back", i), 32'(if_def.in_ready_o), 32'd1);
    endtask

    initial begin
        logic seen;

        // pixels 1, weights 1..9, bias 0 -> 45
        vecs[0] = '{fill(1, 0), fill(1, 1), 32'd0, 32'd45, 16'd45};
        // -128 * -128 * 9 - 1 = 147455; 16-bit wrap -> 16383
        vecs[1] = '{fill(-128, 0), fill(-128, 0), 32'hFFFF_FFFF, 32'd147455, 16'd16383};
        // 2*2*9 + 10 = 46
        vecs[2] = '{fill(2, 0), fill(2, 0), 32'd10, 32'd46, 16'd46};
        // single tap 1 * -20 -> -20
        vecs[3] = '{fill(1, 0), {64'd0, 8'hEC}, 32'd0, 32'hFFFF_FFEC, 16'hFFEC};
        // sum k*(10-k), k=1..9 = 165, plus 100 -> 265
        vecs[4] = '{fill(1, 1), fill(9, -1), 32'd100, 32'd265, 16'd265};
        // 127 * -128 * 9 = -146304; 16-bit -> 0xC480
        vecs[5] = '{fill(127, 0), fill(-128, 0), 32'd0, 32'hFFFD_C480, 16'hC480};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(if_def.in_ready_o), 32'd1);
        check("rst_out_valid", 32'(if_def.out_valid_o), 32'd0);
        check("rst_result", if_def.result_o, 32'd0);
        check("rst_busy", 32'(if_def.busy_o), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure: hold DONE 5 cycles with a new offer pending.
        accept(0);
        wait_def_valid("bp");
        load(2);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(if_def.out_valid_o), 32'd1);
            check($sformatf("bp_result_%0d", k), if_def.result_o, 32'd45);
            check($sformatf("bp_in_ready_%0d", k), 32'(if_def.in_ready_o), 32'd0);
        end
        handshake();
        check("bp_valid_drop", 32'(if_def.out_valid_o), 32'd0);
        check("bp_in_ready", 32'(if_def.in_ready_o), 32'd1);
        tick();   // pending offer accepted on this edge
        in_valid = 1'b0;
        check("bp_next_busy", 32'(if_def.busy_o), 32'd1);
        wait_def_valid("bp2");
        check("bp_next_result", if_def.result_o, 32'd46);
        handshake();

        // Flush in beat 4 together with a new offer.
        accept(4);
        tick(); tick(); tick();   // now in cycle 4 (beat 4)
        load(5);
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_busy", 32'(if_def.busy_o), 32'd0);
        check("fl_out_valid", 32'(if_def.out_valid_o), 32'd0);
        check("fl_in_ready", 32'(if_def.in_ready_o), 32'd1);
        check("fl_result_kept", if_def.result_o, 32'd46);
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (if_def.out_valid_o || if_def.busy_o) seen = 1'b1;
            tick();
        end
        check("fl_no_output", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of ACCUM.
        accept(1);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mr_in_ready", 32'(if_def.in_ready_o), 32'd1);
        check("mr_out_valid", 32'(if_def.out_valid_o), 32'd0);
        check("mr_result", if_def.result_o, 32'd0);
        check("mr_busy", 32'(if_def.busy_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cnn_conv_engine

`default_nettype wire
